// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit right-shifting LFSR (taps 0,2,3,5).
// Seeds a window from the incoming stream, then predicts each bit and tracks errors.
module lfsr_checker #(
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             stuck_zero
);

  typedef enum logic {SEED, LOCKED} state_t;

  localparam logic [4:0]       THR     = 5'(LOSS_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [15:0] w;
  logic [15:0] w_nxt;
  logic [3:0]  seed_cnt;
  logic [3:0]  consec;
  logic        pred;
  logic        mismatch;
  logic        inc;

  // w[0] is the oldest bit, so the window lines up with the generator's state
  assign w_nxt    = {din, w[15:1]};
  assign pred     = w[0] ^ w[2] ^ w[3] ^ w[5];
  assign mismatch = din ^ pred;
  assign inc      = din_valid && (state == LOCKED) && mismatch;
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEED;
      w          <= '0;
      seed_cnt   <= '0;
      consec     <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      stuck_zero <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (clear_cnt)
        err_count <= '0;
      else if (inc && err_count != CNT_MAX)
        err_count <= err_count + CNT_W'(1);
      if (din_valid) begin
        w <= w_nxt;
        case (state)
          SEED: begin
            if (seed_cnt == 4'd15) begin
              seed_cnt <= '0;
              // an all-zero seed would predict zeros forever, so keep seeding
              if (w_nxt != '0) begin
                state  <= LOCKED;
                consec <= '0;
              end else begin
                stuck_zero <= 1'b1;
              end
            end else begin
              seed_cnt <= seed_cnt + 4'd1;
            end
          end
          LOCKED: begin
            err_pulse <= mismatch;
            if (mismatch) begin
              if (({1'b0, consec} + 5'd1) == THR) begin
                state    <= SEED;
                seed_cnt <= '0;
                consec   <= '0;
              end else begin
                consec <= consec + 4'd1;
              end
            end else begin
              consec <= '0;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default and CNT_W=4/LOSS_THRESH=15) share stimulus;
// a reference model feeds a scoreboard, plus table vectors and hand-written corner sequences.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst, din, din_valid, clear_cnt;
  logic locked0, err_pulse0, stuck0;
  logic [15:0] err_count0;
  logic locked1, err_pulse1, stuck1;
  logic [3:0] err_count1;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked0), .err_pulse(err_pulse0), .err_count(err_count0), .stuck_zero(stuck0)
  );

  lfsr_checker #(.LOSS_THRESH(15), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked1), .err_pulse(err_pulse1), .err_count(err_count1), .stuck_zero(stuck1)
  );

  typedef struct {
    bit locked, pulse, stuck;
    int cnt, seedn, consec;
    bit [15:0] win;
  } ms_t;

  typedef struct {
    int inst;
    bit l, p, s;
    int c;
  } exp_t;

  typedef struct {
    bit d;
    bit v;
    bit el;
    bit ep;
  } vec_t;

  ms_t  m0, m1;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  bit [15:0] g;   // generator state
  bit [15:0] bw;  // bits actually sent, for forcing matches/mismatches

  function automatic ms_t mstep(ms_t s, bit d, bit v, bit clr, int thr, int maxc);
    ms_t n = s;
    bit [15:0] nw;
    bit mm;
    n.pulse = 1'b0;
    if (clr) n.cnt = 0;
    if (v) begin
      nw = {d, s.win[15:1]};
      if (!s.locked) begin
        if (s.seedn == 15) begin
          n.seedn = 0;
          if (nw != 16'h0) begin n.locked = 1'b1; n.consec = 0; end
          else n.stuck = 1'b1;
        end else n.seedn = s.seedn + 1;
      end else begin
        mm = d ^ s.win[0] ^ s.win[2] ^ s.win[3] ^ s.win[5];
        n.pulse = mm;
        if (mm) begin
          if (!clr && s.cnt < maxc) n.cnt = s.cnt + 1;
          if (s.consec + 1 == thr) begin n.locked = 1'b0; n.seedn = 0; n.consec = 0; end
          else n.consec = s.consec + 1;
        end else n.consec = 0;
      end
      n.win = nw;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    int al, ap, as, ac;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin al = locked0; ap = err_pulse0; as = stuck0; ac = err_count0; end
      else begin al = locked1; ap = err_pulse1; as = stuck1; ac = err_count1; end
      checks++;
      if (al != e.l || ap != e.p || as != e.s || ac != e.c) begin
        failures++;
        $display("FAIL sb inst%0d @%0t: got l=%0d p=%0d s=%0d c=%0d expected l=%0d p=%0d s=%0d c=%0d",
                 e.inst, $time, al, ap, as, ac, e.l, e.p, e.s, e.c);
      end
    end
  endtask

  task automatic step(input bit d, input bit v, input bit clr, input bit r);
    exp_t e;
    @(negedge clk);
    din = d; din_valid = v; clear_cnt = clr; rst = r;
    if (r) begin
      m0 = '{default: 0}; m1 = '{default: 0}; bw = '0;
    end else begin
      m0 = mstep(m0, d, v, clr, 4, 65535);
      m1 = mstep(m1, d, v, clr, 15, 15);
      if (v) bw = {d, bw[15:1]};
    end
    e = '{0, m0.locked, m0.pulse, m0.stuck, m0.cnt}; sb.push_back(e);
    e = '{1, m1.locked, m1.pulse, m1.stuck, m1.cnt}; sb.push_back(e);
    @(posedge clk); #1;
    check_sb();
  endtask

  task automatic gen_bit(output bit b);
    b = g[0];
    g = {g[0] ^ g[2] ^ g[3] ^ g[5], g[15:1]};
  endtask

  function automatic bit bpred();
    return bw[0] ^ bw[2] ^ bw[3] ^ bw[5];
  endfunction

  task automatic send_gen(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
  endtask

  vec_t tbl[40];

  initial begin
    bit b;
    int pulses, tail, vcount;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0;
    m0 = '{default: 0}; m1 = '{default: 0}; bw = '0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_locked", locked0, 0);
    chk("rst_count", err_count0, 0);
    chk("rst_stuck", stuck0, 0);

    // ACE1 stream, table-driven: lock after the 16th bit, never an error
    g = 16'hACE1;
    for (int i = 0; i < 40; i++) begin
      gen_bit(b);
      tbl[i] = '{b, 1'b1, (i >= 15), 1'b0};
    end
    for (int i = 0; i < 40; i++) begin
      step(tbl[i].d, tbl[i].v, 1'b0, 1'b0);
      chk($sformatf("tbl_locked[%0d]", i), locked0, tbl[i].el);
      chk($sformatf("tbl_pulse[%0d]", i), err_pulse0, tbl[i].ep);
    end
    chk("ace1_count", err_count0, 0);

    // single flipped bit at index 25: pulses at 25, then 36, 38, 39, 41 where it is a tap
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'hACE1; pulses = 0;
    for (int i = 0; i < 50; i++) begin
      gen_bit(b);
      step(b ^ (i == 25), 1'b1, 1'b0, 1'b0);
      if (i == 25) chk("flip_pulse", err_pulse0, 1);
      if (i == 26) chk("flip_pulse_drop", err_pulse0, 0);
      pulses += err_pulse0;
    end
    chk("flip_pulses", pulses, 5);
    chk("flip_count", err_count0, 5);
    chk("flip_locked", locked0, 1);

    // constant ones while locked: lose lock on the 4th consecutive mismatch
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'hACE1;
    send_gen(20);
    tail = 0;
    for (int i = 0; i < 200 && locked0; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      tail = err_pulse0 ? tail + 1 : 0;
    end
    chk("loss_locked", locked0, 0);
    chk("loss_consec", tail, 4);
    g = 16'hACE1;
    send_gen(15);
    chk("reseed_15", locked0, 0);
    send_gen(1);
    chk("reseed_16", locked0, 1);

    // all-zero seed then seed 0001
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_locked", locked0, 0);
    chk("zero_stuck", stuck0, 1);
    g = 16'h0001;
    send_gen(16);
    chk("one_locked", locked0, 1);
    chk("one_stuck", stuck0, 1);

    // valid gaps 1,0,0: same lock point in valid bits, no errors
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'hACE1; vcount = 0;
    for (int i = 0; i < 30; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      vcount++;
      if (vcount == 15) chk("gap_lock15", locked0, 0);
      if (vcount == 16) chk("gap_lock16", locked0, 1);
      step(1'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    chk("gap_count", err_count0, 0);
    step(~bpred(), 1'b1, 1'b0, 1'b0);
    chk("force_count", err_count0, 1);
    step(bpred(), 1'b1, 1'b0, 1'b0);
    step(~bpred(), 1'b1, 1'b1, 1'b0);
    chk("clr_pulse", err_pulse0, 1);
    chk("clr_count", err_count0, 0);

    // reset mid-seed and while locked
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'hACE1;
    send_gen(8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midseed_locked", locked0, 0);
    g = 16'hACE1;
    send_gen(15);
    chk("midseed_15", locked0, 0);
    send_gen(1);
    chk("midseed_16", locked0, 1);
    step(~bpred(), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("lockrst_locked", locked0, 0);
    chk("lockrst_count", err_count0, 0);
    g = 16'hACE1;
    send_gen(15);
    chk("lockrst_15", locked0, 0);
    send_gen(1);
    chk("lockrst_16", locked0, 1);

    // saturation on CNT_W=4: 20 mismatches with a correct bit after every two
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'hACE1;
    send_gen(20);
    for (int i = 0; i < 20; i++) begin
      step(~bpred(), 1'b1, 1'b0, 1'b0);
      if (i % 2 == 1) step(bpred(), 1'b1, 1'b0, 1'b0);
    end
    chk("sat_count", err_count1, 15);
    chk("sat_locked", locked1, 1);
    chk("nosat_count", err_count0, 20);
    chk("nosat_locked", locked0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial receive-side companion to the team's 16-bit right-shifting LFSR generator (taps 0, 2, 3, 5; serial output is q[0] on each shift).
- Consumes the generator's bit stream one bit per valid cycle and self-synchronizes by seeding a 16-bit window from the received bits.
- Once synchronized, predicts every following bit and reports mismatches, loss of lock and a saturating error count.
- Used in BIST and link loopback benches.

Parameters:
LOSS_THRESH, 4, consecutive mismatches in LOCKED that force return to SEED (legal range 1..15)
CNT_W, 16, width of error counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
din  input  1  received serial bit (generator q[0])
din_valid  input  1  din is sampled only in cycles where this is 1
clear_cnt  input  1  synchronous clear of err_count
locked  output  1  1 while in LOCKED state
err_pulse  output  1  one-cycle flag: the previous valid bit mismatched the prediction
err_count  output  CNT_W  saturating count of mismatches since reset/clear
stuck_zero  output  1  sticky: a seed attempt completed with an all-zero window

Behaviour:
- Reset (rst=1 at an edge, highest priority, also mid-operation):
  - window=0, seed_cnt=0, consec=0, state=SEED.
  - locked=0, err_pulse=0, err_count=0, stuck_zero=0.
- Window w[15:0]:
  - On every valid bit in any state, w <= {din, w[15:1]}.
  - w[0] is the oldest bit, mirroring the generator state.
  - Prediction pred = w[0]^w[2]^w[3]^w[5], computed from w before the shift.
- Cycles with din_valid=0 change nothing except err_pulse, which returns to 0.
- State SEED:
  - Each valid bit increments seed_cnt (4 bits).
  - On the 16th valid bit (seed_cnt==15), compute the post-shift window:
    - nonzero: state <= LOCKED; seed_cnt <= 0; consec <= 0.
    - zero: stay SEED; seed_cnt <= 0; stuck_zero <= 1.
  - No comparison is made in SEED; err_pulse stays 0.
- State LOCKED:
  - Each valid bit sets mismatch = din ^ pred.
  - err_pulse <= mismatch, with one-cycle latency after the sampled bit.
  - Mismatch: consec <= consec+1. Match: consec <= 0.
  - If consec+1 == LOSS_THRESH on a mismatch: state <= SEED, seed_cnt <= 0, consec <= 0.
  - The bit that triggers loss of lock is still shifted in and still counted as an error.
- Outputs:
  - locked is registered: it equals (state==LOCKED) and rises on the edge that samples the 16th seed bit.
- err_count:
  - Increments by 1 on each mismatch and saturates at 2^CNT_W-1 without wrapping.
  - clear_cnt=1 sets it to 0 and takes priority over a simultaneous increment (result 0).
  - clear_cnt does not affect state, window or stuck_zero.
- stuck_zero clears only on rst.

Test Plan:
- Generator seeded 16'hACE1, 40 valid bits (first 16 LSB-first: 1,0,0,0,0,1,1,1,0,0,1,1,0,1,0,1) -> locked=1 after the 16th bit; the 17th bit is predicted 0 and matches; err_pulse stays 0; err_count=0 at end.
- Locked stream with a single bit flipped at bit 25 -> err_pulse=1 for exactly one cycle after bit 25. Expect additional one-cycle pulses afterwards, because the corrupt bit is re-used as a tap; err_count equals the number of pulses; locked stays 1 with LOSS_THRESH=4.
- Locked stream, then constant 1s with din_valid=1 -> locked falls on the edge sampling the mismatch that makes consec reach 4. Re-seeding on a valid 'ACE1' stream then relocks after 16 more bits.
- 16 valid zeros after reset -> locked stays 0, stuck_zero=1. Next 16 bits from seed 16'h0001 -> locked=1; stuck_zero stays 1.
- valid gaps: stream from 'ACE1' with din_valid toggling 1,0,0,1,... -> identical lock point in valid-bit count and no errors. clear_cnt asserted together with a forced mismatch -> err_count=0 and err_pulse=1.
- rst asserted after 8 seed bits and again while locked -> next cycle locked=0, err_count=0, and a fresh 16-bit seed is required to lock; CNT_W=4 with 20 forced mismatches, LOSS_THRESH=15, periodic correct bits -> err_count holds at 15.
